// File: rtl/minterm_lut.sv
// rtl/minterm_lut.sv - table-driven N-input boolean function with exhaustive-sweep engine
// Sweep engine (FSM, index counter, minterm accumulator) is compiled in only with MINTERM_LUT_SWEEP_EN.
module minterm_lut #(
   parameter int N = 4,
   parameter logic [(1<<N)-1:0] INIT = 16'hEF77
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_vld,
   input  logic [N-1:0] in_x,
   input  logic         tbl_we,
   input  logic [N-1:0] tbl_addr,
   input  logic         tbl_din,
   input  logic         sweep_start,
   output logic         f_vld,
   output logic         f,
   output logic [N-1:0] f_x,
   output logic         sweep_busy,
   output logic         sweep_done,
   output logic [N:0]   sweep_count
);

   localparam int D = 1 << N;

   logic [D-1:0] tbl_q;
   logic         f_vld_q;
   logic         f_q;
   logic [N-1:0] f_x_q;
   logic         run_w;
   logic [N-1:0] sweep_idx;

`ifdef MINTERM_LUT_SWEEP_EN
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t       state_q;
   logic [N-1:0] idx_q;
   logic [N:0]   acc_q;
   logic [N:0]   count_q;
   logic         busy_q;
   logic         done_q;
   logic [N:0]   acc_inc;

   assign run_w     = (state_q == RUN);
   assign sweep_idx = idx_q;
   assign acc_inc   = acc_q + (N+1)'(tbl_q[idx_q]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         acc_q   <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sweep_start) begin
                  state_q <= RUN;
                  idx_q   <= '0;
                  acc_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               acc_q <= acc_inc;
               if (idx_q == '1) begin
                  // count is published only here, so it holds across idle periods
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  count_q <= acc_inc;
               end else begin
                  idx_q <= idx_q + N'(1);
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sweep_busy  = busy_q;
   assign sweep_done  = done_q;
   assign sweep_count = count_q;
`else
   logic unused_sweep_start;

   assign unused_sweep_start = sweep_start;
   assign run_w       = 1'b0;
   assign sweep_idx   = '0;
   assign sweep_busy  = 1'b0;
   assign sweep_done  = 1'b0;
   assign sweep_count = '0;
`endif

   // While a sweep runs the table is frozen and the output port carries the sweep stream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tbl_q   <= INIT;
         f_vld_q <= 1'b0;
         f_q     <= 1'b0;
         f_x_q   <= '0;
      end else begin
         if (tbl_we && !run_w) begin
            tbl_q[tbl_addr] <= tbl_din;
         end
         if (run_w) begin
            f_vld_q <= 1'b1;
            f_q     <= tbl_q[sweep_idx];
            f_x_q   <= sweep_idx;
         end else begin
            f_vld_q <= in_vld;
            if (in_vld) begin
               f_q   <= tbl_q[in_x];
               f_x_q <= in_x;
            end
         end
      end
   end

   assign f_vld = f_vld_q;
   assign f     = f_q;
   assign f_x   = f_x_q;

endmodule

// File: tb/tb_minterm_lut.sv
// tb/tb_minterm_lut.sv - self-checking bench for minterm_lut (sweep tests need MINTERM_LUT_SWEEP_EN)
module tb_minterm_lut;

   localparam int N = 4;
   localparam int D = 16;
   localparam logic [15:0] INIT = 16'hEF77;
`ifdef MINTERM_LUT_SWEEP_EN
   localparam bit SW = 1'b1;
`else
   localparam bit SW = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_vld = 1'b0;
   logic [N-1:0] in_x = '0;
   logic         tbl_we = 1'b0;
   logic [N-1:0] tbl_addr = '0;
   logic         tbl_din = 1'b0;
   logic         sweep_start = 1'b0;
   logic         f_vld;
   logic         f;
   logic [N-1:0] f_x;
   logic         sweep_busy;
   logic         sweep_done;
   logic [N:0]   sweep_count;

   minterm_lut #(.N(N), .INIT(INIT)) dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_x(in_x),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_din(tbl_din),
      .sweep_start(sweep_start), .f_vld(f_vld), .f(f), .f_x(f_x),
      .sweep_busy(sweep_busy), .sweep_done(sweep_done), .sweep_count(sweep_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model: a truth-table array plus the cycle number of the accepted sweep start.
   bit mtbl [D];
   int c = 0;
   int s = -1000;
   bit e_vld, e_f, e_busy, e_done;
   int e_x, e_cnt;
   logic [15:0] init_v = INIT;

   function automatic int popc();
      int n = 0;
      for (int i = 0; i < D; i++) n += int'(mtbl[i]);
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      bit run, dn;
      if (rst) begin
         for (int i = 0; i < D; i++) mtbl[i] = init_v[i];
         s = -1000;
         e_vld = 0; e_f = 0; e_busy = 0; e_done = 0; e_x = 0; e_cnt = 0;
      end else begin
         run = SW && (c >= s + 1) && (c <= s + D);
         dn  = SW && (c == s + D + 1);
         if (run) begin
            e_vld = 1'b1;
            e_x   = c - s - 1;
            e_f   = mtbl[e_x];
         end else begin
            e_vld = in_vld;
            if (in_vld) begin
               e_x = int'(in_x);
               e_f = mtbl[in_x];
            end
         end
         if (tbl_we && !run) mtbl[tbl_addr] = tbl_din;
         if (SW && sweep_start && !run && !dn) s = c;
         e_busy = SW && (c >= s) && (c <= s + D - 1);
         e_done = SW && (c == s + D);
         if (e_done) e_cnt = popc();
         c++;
      end
   end

   always @(negedge clk) begin
      if (!rst && chk_en) begin
         chk("mdl_f_vld", int'(f_vld), int'(e_vld));
         if (e_vld) begin
            chk("mdl_f", int'(f), int'(e_f));
            chk("mdl_f_x", int'(f_x), e_x);
         end
         chk("mdl_busy", int'(sweep_busy), int'(e_busy));
         chk("mdl_done", int'(sweep_done), int'(e_done));
         chk("mdl_count", int'(sweep_count), e_cnt);
      end
   end

   task automatic eval(input int x, input int exp);
      @(negedge clk);
      in_vld = 1'b1; in_x = N'(x);
      @(negedge clk);
      in_vld = 1'b0;
      chk($sformatf("eval_f_%0d", x), int'(f), exp);
      chk($sformatf("eval_fx_%0d", x), int'(f_x), x);
      chk($sformatf("eval_vld_%0d", x), int'(f_vld), 1);
   endtask

   task automatic wr(input int a, input int d);
      @(negedge clk);
      tbl_we = 1'b1; tbl_addr = N'(a); tbl_din = d[0];
      @(negedge clk);
      tbl_we = 1'b0;
   endtask

   // Runs one sweep started at cycle 0; noise=1 pokes inputs during RUN and DONE.
   task automatic sweep(input string nm, input bit noise);
      int nb = 0, nv = 0, nd = 0, dk = 0, cnt = -1, bad = 0;
      logic [15:0] pat = '0;
      @(negedge clk);
      sweep_start = 1'b1;
      @(negedge clk);
      sweep_start = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         if (sweep_busy) nb++;
         if (f_vld) begin
            nv++;
            pat[f_x] = f;
            if (int'(f_x) != k - 2) bad++;
         end
         if (sweep_done) begin nd++; dk = k; cnt = int'(sweep_count); end
         if (noise && (k == 5)) begin
            in_vld = 1'b1; in_x = 4'd12; tbl_we = 1'b1; tbl_addr = 4'd12; tbl_din = 1'b1;
            sweep_start = 1'b1;
         end else if (noise && (k == 17)) begin
            sweep_start = 1'b1;
         end else begin
            in_vld = 1'b0; tbl_we = 1'b0; sweep_start = 1'b0;
         end
         @(negedge clk);
      end
      chk({nm, "_busy_cycles"}, nb, 16);
      chk({nm, "_vld_cycles"}, nv, 16);
      chk({nm, "_order_errs"}, bad, 0);
      chk({nm, "_pattern"}, int'(pat), int'(16'hEF77));
      chk({nm, "_done_pulses"}, nd, 1);
      chk({nm, "_done_cycle"}, dk, 17);
      chk({nm, "_count"}, cnt, 13);
   endtask

   initial begin
      int found, nd;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_f_vld", int'(f_vld), 0);
      chk("rst_f", int'(f), 0);
      chk("rst_f_x", int'(f_x), 0);
      chk("rst_busy", int'(sweep_busy), 0);
      chk("rst_done", int'(sweep_done), 0);
      chk("rst_count", int'(sweep_count), 0);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      eval(3, 0); eval(7, 0); eval(12, 0);
      eval(0, 1); eval(5, 1); eval(15, 1);
      @(negedge clk);
      chk("f_vld_falls", int'(f_vld), 0);

      wr(3, 1);
      eval(3, 1);
      @(negedge clk);
      tbl_we = 1'b1; tbl_addr = 4'd7; tbl_din = 1'b1; in_vld = 1'b1; in_x = 4'd7;
      @(negedge clk);
      tbl_we = 1'b0; in_vld = 1'b0;
      chk("same_cycle_old_f", int'(f), 0);
      eval(7, 1);
      wr(3, 0); wr(7, 0);

      if (SW) begin
         sweep("sweep", 1'b0);
         sweep("noisy", 1'b1);
         eval(12, 0);

         // simultaneous eval + start, then the earliest back-to-back restart
         @(negedge clk);
         in_vld = 1'b1; in_x = 4'd5; sweep_start = 1'b1;
         @(negedge clk);
         in_vld = 1'b0; sweep_start = 1'b0;
         chk("simul_f_x", int'(f_x), 5);
         chk("simul_f", int'(f), 1);
         found = 0;
         for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge clk);
            if (sweep_done) found = 1;
         end
         chk("simul_done_seen", found, 1);
         @(negedge clk);
         sweep_start = 1'b1;
         @(negedge clk);
         sweep_start = 1'b0;
         chk("restart_busy", int'(sweep_busy), 1);
         found = 0;
         for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge clk);
            if (sweep_done) found = 1;
         end
         chk("restart_done_seen", found, 1);
         chk("restart_count", int'(sweep_count), 13);

         wr(0, 0);
         @(negedge clk);
         sweep_start = 1'b1;
         @(negedge clk);
         sweep_start = 1'b0;
         found = 0;
         for (int k = 0; k < 40 && found == 0; k++) begin
            if (f_vld && f_x == 4'd8) found = 1;
            else @(negedge clk);
         end
         chk("rst_mid_reach_x8", found, 1);
         #2 rst = 1'b1;
         #1;
         chk("amid_f_vld", int'(f_vld), 0);
         chk("amid_f", int'(f), 0);
         chk("amid_f_x", int'(f_x), 0);
         chk("amid_busy", int'(sweep_busy), 0);
         chk("amid_count", int'(sweep_count), 0);
         @(negedge clk);
         @(negedge clk);
         rst = 1'b0;
         nd = 0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sweep_done) nd++;
         end
         chk("no_done_after_rst", nd, 0);
         eval(0, 1);
         sweep("post_rst", 1'b0);
      end else begin
         @(negedge clk);
         sweep_start = 1'b1;
         @(negedge clk);
         sweep_start = 1'b0;
         for (int k = 0; k < 20; k++) begin
            chk("nosw_busy", int'(sweep_busy), 0);
            chk("nosw_done", int'(sweep_done), 0);
            chk("nosw_count", int'(sweep_count), 0);
            @(negedge clk);
         end
         eval(3, 0); eval(12, 0); eval(15, 1);
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
